// File: rtl/mem_wb_register.sv
// MEM/WB pipeline register: captures memory-stage results and writeback control,
// with stall/flush and a retired-instruction counter. Define MEM_WB_SUBWORD_LOAD_EN
// to enable big-endian byte/halfword load alignment and extension.
module mem_wb_register #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   EX_MEM_valid,
  input  logic                   EX_MEM_register_write,
  input  logic                   EX_MEM_memory_to_register,
  input  logic [4:0]             EX_MEM_write_register,
  input  logic [31:0]            EX_MEM_alu_result,
  input  logic [1:0]             EX_MEM_load_size,
  input  logic                   EX_MEM_load_unsigned,
  input  logic [31:0]            memory_read_data,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   MEM_WB_valid,
  output logic                   MEM_WB_register_write,
  output logic                   MEM_WB_memory_to_register,
  output logic [4:0]             MEM_WB_write_register,
  output logic [31:0]            MEM_WB_alu_result,
  output logic [31:0]            MEM_WB_read_data,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  logic                   valid_q, valid_d;
  logic                   reg_write_q, reg_write_d;
  logic                   mem_to_reg_q, mem_to_reg_d;
  logic [4:0]             write_reg_q, write_reg_d;
  logic [31:0]            alu_result_q, alu_result_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [31:0]            aligned_data;

`ifdef MEM_WB_SUBWORD_LOAD_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (EX_MEM_alu_result[1:0])
      2'd0:    byte_sel = memory_read_data[31:24];
      2'd1:    byte_sel = memory_read_data[23:16];
      2'd2:    byte_sel = memory_read_data[15:8];
      default: byte_sel = memory_read_data[7:0];
    endcase
    // offset[0] is ignored for halfwords: no misalignment trap
    half_sel = EX_MEM_alu_result[1] ? memory_read_data[15:0] : memory_read_data[31:16];

    unique case (EX_MEM_load_size)
      2'b01:   aligned_data = {{16{half_sel[15] & ~EX_MEM_load_unsigned}}, half_sel};
      2'b10:   aligned_data = {{24{byte_sel[7] & ~EX_MEM_load_unsigned}}, byte_sel};
      default: aligned_data = memory_read_data;
    endcase
  end
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{EX_MEM_load_size, EX_MEM_load_unsigned};
  assign aligned_data     = memory_read_data;
`endif

  // Priority: flush > stall > capture; reset is applied in the register process.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    write_reg_d  = write_reg_q;
    alu_result_d = alu_result_q;
    read_data_d  = read_data_q;
    count_d      = count_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      write_reg_d  = 5'd0;
      alu_result_d = 32'd0;
      read_data_d  = 32'd0;
    end else if (!stall) begin
      valid_d      = EX_MEM_valid;
      reg_write_d  = EX_MEM_register_write & EX_MEM_valid & (EX_MEM_write_register != 5'd0);
      mem_to_reg_d = EX_MEM_memory_to_register & EX_MEM_valid;
      write_reg_d  = EX_MEM_write_register;
      alu_result_d = EX_MEM_alu_result;
      read_data_d  = aligned_data;
      if (EX_MEM_valid) begin
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      write_reg_q  <= 5'd0;
      alu_result_q <= 32'd0;
      read_data_q  <= 32'd0;
      count_q      <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      write_reg_q  <= write_reg_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      count_q      <= count_d;
    end
  end

  assign MEM_WB_valid              = valid_q;
  assign MEM_WB_register_write     = reg_write_q;
  assign MEM_WB_memory_to_register = mem_to_reg_q;
  assign MEM_WB_write_register     = write_reg_q;
  assign MEM_WB_alu_result         = alu_result_q;
  assign MEM_WB_read_data          = read_data_q;
  assign retired_count             = count_q;

endmodule
